// File: rtl/isp_pkg.sv
// Shared ISP stream types: default raster constants and the tagged-pixel record
// carried between the gray receiver and its skid buffer.
package isp_pkg;

  localparam int ISP_IMG_W  = 1920;
  localparam int ISP_IMG_H  = 1080;
  localparam int ISP_PIX_DW = 8;

  // Coordinate width that stays legal for 1-pixel dimensions.
  function automatic int isp_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ISP_XW = isp_cw(ISP_IMG_W);
  localparam int ISP_YW = isp_cw(ISP_IMG_H);

  typedef struct packed {
    logic [ISP_PIX_DW-1:0] data;
    logic [ISP_XW-1:0]     x;
    logic [ISP_YW-1:0]     y;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } isp_pix_tag_t;

endpackage

// File: rtl/isp_skid2.sv
// Two-entry valid/ready buffer for tagged pixels; head entry drives the output
// and in_ready comes straight from a flop.
module isp_skid2
  import isp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  isp_pix_tag_t in_tag,
  input  logic         in_valid,
  output logic         in_ready,
  output isp_pix_tag_t out_tag,
  output logic         out_valid,
  input  logic         out_ready
);

  isp_pix_tag_t head;
  isp_pix_tag_t skid;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic         push;
  logic         pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_tag   = head;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt - 2'd1;
  end

  // in_ready is low whenever cnt is 2, so push and pop never meet at full.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      head     <= '0;
      skid     <= '0;
      in_ready <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != 2'd2);
      if (pop) begin
        head <= (cnt == 2'd2) ? skid : in_tag;
      end else if (push) begin
        if (cnt == 2'd0)
          head <= in_tag;
        else
          skid <= in_tag;
      end
    end
  end

endmodule

// File: rtl/isp_gray_rx.sv
// Gray pixel stream receiver: tags each accepted pixel with raster position and
// frame flags. Optional completed-frame counter under ISP_GRAY_RX_FRMCNT_EN.
module isp_gray_rx
  import isp_pkg::*;
#(
  parameter int IMG_W = ISP_IMG_W,
  parameter int IMG_H = ISP_IMG_H,
  parameter int DW    = ISP_PIX_DW
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             data_m_gray,
  input  logic                      valid_m,
  output logic                      ready_m,
  output logic [DW-1:0]             data_s_gray,
  output logic                      valid_s,
  input  logic                      ready_s,
  output logic [isp_cw(IMG_W)-1:0]  x_s,
  output logic [isp_cw(IMG_H)-1:0]  y_s,
  output logic                      sof_s,
  output logic                      eol_s,
  output logic                      eof_s
`ifdef ISP_GRAY_RX_FRMCNT_EN
  ,
  output logic [15:0]               frame_cnt
`endif
);

  localparam int XW = isp_cw(IMG_W);
  localparam int YW = isp_cw(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] xc;
  logic [YW-1:0] yc;
  logic          in_acc;
  isp_pix_tag_t  in_tag;
  isp_pix_tag_t  out_tag;

  assign in_acc = valid_m && ready_m;

  always_comb begin
    in_tag      = '0;
    in_tag.data = ISP_PIX_DW'(data_m_gray);
    in_tag.x    = ISP_XW'(xc);
    in_tag.y    = ISP_YW'(yc);
    in_tag.sof  = (xc == '0) && (yc == '0);
    in_tag.eol  = (xc == X_LAST);
    in_tag.eof  = (xc == X_LAST) && (yc == Y_LAST);
  end

  // Raster position advances only on input handshakes; frames run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      xc <= '0;
      yc <= '0;
    end else if (in_acc) begin
      if (xc == X_LAST) begin
        xc <= '0;
        yc <= (yc == Y_LAST) ? '0 : yc + 1'b1;
      end else begin
        xc <= xc + 1'b1;
      end
    end
  end

  isp_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_tag    (in_tag),
    .in_valid  (valid_m),
    .in_ready  (ready_m),
    .out_tag   (out_tag),
    .out_valid (valid_s),
    .out_ready (ready_s)
  );

  assign data_s_gray = DW'(out_tag.data);
  assign x_s         = XW'(out_tag.x);
  assign y_s         = YW'(out_tag.y);
  assign sof_s       = out_tag.sof;
  assign eol_s       = out_tag.eol;
  assign eof_s       = out_tag.eof;

`ifdef ISP_GRAY_RX_FRMCNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_q <= 16'd0;
    else if (valid_s && ready_s && eof_s)
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/isp_gray_rx.md
# isp_gray_rx

Stream receiver and frame tagger for the 8-bit gray pixel stream leaving `isp_csc`. Sits between `isp_csc` and the Sobel line buffers. Accepts pixels on a valid/ready handshake with arbitrary source gaps, and absorbs downstream back-pressure in a 2-entry skid buffer. Re-emits each pixel tagged with raster coordinates and start-of-frame, end-of-line and end-of-frame flags.

## Interface
Parameters:
- `IMG_W`, 1920: pixels per line.
- `IMG_H`, 1080: lines per frame.
- `DW`, 8: pixel width.

Ports:
- `clk`  in  1  single clock, 75 MHz nominal.
- `rst`  in  1  reset, synchronous, active-high.
- `data_m_gray`  in  DW  input pixel from `isp_csc`.
- `valid_m`  in  1  input pixel valid.
- `ready_m`  out  1  receiver can accept; driven directly from a flop.
- `data_s_gray`  out  DW  output pixel.
- `valid_s`  out  1  output pixel valid.
- `ready_s`  in  1  downstream accepts.
- `x_s`  out  $clog2(IMG_W)  column of the output pixel.
- `y_s`  out  $clog2(IMG_H)  line of the output pixel.
- `sof_s`  out  1  output pixel is (0,0).
- `eol_s`  out  1  output pixel is at column IMG_W-1.
- `eof_s`  out  1  output pixel is (IMG_W-1, IMG_H-1).
- `frame_cnt`  out  16  completed-frame count. Present only with `ISP_GRAY_RX_FRMCNT_EN`.

## Operation
- Input accept: `valid_m && ready_m`. Output accept: `valid_s && ready_s`.
- Tag counters `xc`/`yc` advance on every input accept.
- `xc` wraps IMG_W-1 → 0 and increments `yc`.
- `yc` wraps IMG_H-1 → 0, so the next frame starts at (0,0) with no gap.
- Each accepted pixel is stored in the buffer together with its {data, x, y, sof, eol, eof} tag.
  - sof = (xc==0 && yc==0).
  - eol = (xc==IMG_W-1).
  - eof = eol && (yc==IMG_H-1).
- Buffer: 2-entry FIFO with occupancy `cnt` ∈ {0,1,2}. The head entry drives the `_s` outputs. `valid_s = (cnt!=0)`.
- `ready_m` is a flop, loaded each cycle with (next `cnt` != 2).
- Push and pop in the same cycle: `cnt` is unchanged, the head advances, and the new entry is written behind it.
- `valid_s` and `data_s_gray`/tags are held stable while `valid_s && !ready_s`. This is AXI-style: no retraction and no data change until accepted.
- Input `valid_m` may drop at any cycle and may rise without regard to `ready_m`. Only handshakes count.
- No pixel is dropped or duplicated. The output sequence equals the input sequence.
- Arithmetic: counters are unsigned and compare against constants only. `frame_cnt` wraps 0xFFFF → 0.

## Timing
- Reset (`rst`=1 at a clk edge), next cycle:
  - `cnt`=0, `xc`=`yc`=0.
  - `valid_s`=0, `ready_m`=0.
  - `data_s_gray`=0, `x_s`=`y_s`=0, all flags 0, `frame_cnt`=0.
- First cycle after `rst` deasserts: `ready_m`=1.
- Latency: input accept at edge N makes `valid_s`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 pixel/cycle when `ready_s` is held at 1.
- Full: `cnt`=2 gives `ready_m`=0 from the following cycle. The skid entry absorbs the pixel accepted in the cycle `ready_s` fell.
- Reset mid-frame: buffered pixels are discarded and the counters return to (0,0). The next accepted pixel carries sof=1.
- Single-pixel case: a 1×1 frame (`IMG_W`=`IMG_H`=1) sets sof, eol and eof on every pixel.

## Configuration
- `ISP_GRAY_RX_FRMCNT_EN` defined:
  - `frame_cnt` port and register exist.
  - The counter increments on each output accept with `eof_s`=1.
- Undefined: no port, no register. All other behaviour is identical.

## Structure
- Shared package `isp_pkg`:
  - typedef `isp_pix_tag_t` (packed struct {data, x, y, sof, eol, eof}), parameterised widths derived from constants.
  - constants `ISP_IMG_W`=1920, `ISP_IMG_H`=1080, `ISP_PIX_DW`=8.
- Sub-module `isp_skid2`: generic 2-entry valid/ready buffer over `isp_pix_tag_t`, with flop-driven ready. Tag generation and the frame counter stay in `isp_gray_rx`.

## Test plan
- Reset, then a 4×2 frame (`IMG_W`=4, `IMG_H`=2), `ready_s`=1, continuous `valid_m`, data 0..7 → outputs 0..7 one per cycle, 1 cycle behind input. sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
- Random `valid_m` (50%) and random `ready_s` (50%) over 3 frames of 1920×1080 with incrementing data → output sequence matches, the (x,y) tags match the raster position, and `valid_s`/data are never changed while stalled.
- `ready_s`=0 with continuous input → exactly 2 pixels accepted, then `ready_m`=0. Releasing `ready_s` delivers them in order with no loss.
- `rst` pulsed after 5 pixels of a 4×2 frame → `valid_s`=0 and `ready_m`=0 the next cycle. The first pixel after reset carries sof=1 with x=y=0.
- With `ISP_GRAY_RX_FRMCNT_EN`: three 4×2 frames → `frame_cnt` reads 1, 2, 3 after each eof handshake. Preload `frame_cnt` via force to 0xFFFF and complete one frame → 0.
